program_loader: RTL and testbench
=================================

# program_loader

Writer side of the instruction memory that `instruction_fetch` reads. It takes a byte stream from the UART receiver of the debug unit and assembles big-endian 32-bit words. It writes them to consecutive instruction-memory word addresses starting at 0 and holds the CPU disabled until the program is complete. Loading ends at the HALT word, which is stored, or when memory is full.

## Interface
Parameters:
- `LEN`, 32: instruction width in bits; must be a multiple of 8.
- `ADDR_W`, 10: instruction-memory word-address width (depth 2^ADDR_W).
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_start`  in  1  one-cycle pulse; arms, or re-arms, a load.
- `in_rx_data`  in  8  received byte; valid only when `in_rx_done`=1.
- `in_rx_done`  in  1  one-cycle strobe, one per byte.
- `out_wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `out_wr_addr`  out  ADDR_W  word address for the write.
- `out_wr_data`  out  LEN  word to write.
- `out_busy`  out  1  1 while in LOAD.
- `out_done`  out  1  1 while in DONE.
- `out_overflow`  out  1  set in DONE when memory filled without a HALT word.
- `out_word_count`  out  ADDR_W+1  number of words written in this load.
- `out_cpu_enable`  out  1  equals `out_done & ~out_overflow`; gates the pipeline clock enable.

## Operation
- **States:** IDLE, LOAD, WRITE, DONE.
- **IDLE:** ignores bytes. `in_start` → LOAD; clears the byte counter, address, word count and overflow.
- **LOAD:**
  - Each `in_rx_done` shifts the byte into the assembly register, MSB first: the first byte lands in [LEN-1:LEN-8]. The byte counter then increments.
  - The byte that completes a word (counter = LEN/8-1) latches the word into `out_wr_data` → WRITE. The counter returns to 0.
- **WRITE:** one cycle.
  - `out_wr_en`=1 with the current address.
  - `out_word_count` increments at the end of the cycle.
  - If the word equals `HALT_WORD` → DONE, `out_overflow`=0.
  - Else if the address = 2^ADDR_W-1 → DONE, `out_overflow`=1.
  - Else the address increments → LOAD.
- **DONE:** holds outputs and ignores bytes. `in_start` → LOAD with all counters cleared.
- **`in_start` in LOAD or WRITE:** aborts the load and restarts at address 0. A write pending in the same cycle is still issued; the counters are cleared afterwards.
- **`in_start` and `in_rx_done` in the same cycle:** start wins and the byte is discarded.
- **`in_rx_done` during WRITE:** the byte is accepted as byte 0 of the next word. The assembly register and counter are independent of the write strobe, so no byte is lost at 1-cycle byte spacing.
- **Partial word at restart or reset:** discarded, not written.

## Timing
- **Reset values:** state IDLE; every output 0 (`out_wr_addr`, `out_wr_data`, `out_word_count` included).
- **Reset mid-load:** the next cycle is IDLE with all outputs 0. No write is issued in that cycle.
- **Write latency:** `out_wr_en` rises exactly 1 cycle after the `in_rx_done` of the word's last byte. Address and data are stable in that cycle.
- **Status latency:**
  - `out_done` / `out_cpu_enable` rise 1 cycle after the HALT write strobe.
  - `out_busy` rises 1 cycle after `in_start`.
- **Throughput:** one byte per cycle sustained; one word per LEN/8 bytes.
- **Arithmetic:**
  - `out_wr_addr` never wraps; the full condition terminates the load instead.
  - `out_word_count` reaches at most 2^ADDR_W, hence ADDR_W+1 bits.

## Structure
- Shared package `mips_pkg`:
  - loader state typedef/localparams (IDLE=0, LOAD=1, WRITE=2, DONE=3);
  - `HALT_WORD` default;
  - `BYTES_PER_WORD = LEN/8`.
- One sub-module, `word_assembler`:
  - byte shift register plus byte counter;
  - inputs: byte, strobe, clear;
  - outputs: word, word_valid pulse.
- The top FSM, address counter and status flags stay in `program_loader`.

## Test plan
- **Basic load:** reset low 2 cycles, then `in_start`, then bytes 20,08,00,05, 20,09,00,07, FF,FF,FF,FF. Expect:
  - writes (0,0x20080005), (1,0x20090007), (2,0xFFFFFFFF), each 1 cycle after its 4th byte;
  - `out_done`=1, `out_cpu_enable`=1, `out_word_count`=3.
- **Back-to-back bytes:** `in_rx_done` high 12 consecutive cycles with the same stream → identical three writes, no byte lost.
- **Overflow:** with `ADDR_W`=2, send 4 non-HALT words → writes at addresses 0..3, then DONE, `out_overflow`=1, `out_cpu_enable`=0, `out_word_count`=4.
- **Restart mid-word:**
  - send 2 bytes, then `in_start` coincident with the 3rd byte;
  - then send 00,00,00,01 and the HALT word;
  - expect the first write at address 0 with data 0x00000001; the partial and coincident bytes are dropped.
- **Reset mid-operation:** drive reset low in the WRITE cycle. The next cycle has every output 0 and state IDLE, and bytes are ignored until `in_start`.
- **Reload from DONE:** `in_start` after a completed load → `out_done` falls and `out_busy` rises 1 cycle later, and the new program writes from address 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory program loader.
package mips_pkg;

    localparam int unsigned INSTR_LEN = 32;
    localparam int unsigned BYTES_PER_WORD = INSTR_LEN / 8;
    localparam logic [INSTR_LEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in from the UART receiver and word write bus out to instruction memory.
interface program_loader_if
    import mips_pkg::*;
#(
    parameter int unsigned LEN    = INSTR_LEN,
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        in_rx_data;
    logic              in_rx_done;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [LEN-1:0]    out_wr_data;

    modport master (
        input  in_rx_data,
        input  in_rx_done,
        output out_wr_en,
        output out_wr_addr,
        output out_wr_data
    );

    modport slave (
        output in_rx_data,
        output in_rx_done,
        input  out_wr_en,
        input  out_wr_addr,
        input  out_wr_data
    );
endinterface

// File: rtl/word_assembler.sv
// Shifts received bytes MSB-first into a word; flags the byte that completes it.
// LEN must be a multiple of 8 and at least 16.
module word_assembler #(
    parameter int unsigned LEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     i_byte,
    input  logic           i_strobe,
    input  logic           i_clear,
    output logic [LEN-1:0] o_word_c,
    output logic           o_word_valid_c
);
    localparam int unsigned BPW   = LEN / 8;
    localparam int unsigned CNT_W = $clog2(BPW + 1);

    logic [LEN-9:0]   r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last         = (r_cnt == CNT_W'(BPW - 1));
    assign o_word_c       = {r_shift, i_byte};
    // Clear takes priority: a byte arriving with clear is dropped.
    assign o_word_valid_c = i_strobe & ~i_clear & w_last;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_strobe) begin
            r_shift <= o_word_c[LEN-9:0];
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/program_loader.sv
// Loads a program byte stream into instruction memory and holds the CPU off until it completes.
module program_loader
    import mips_pkg::*;
#(
    parameter int unsigned    LEN       = INSTR_LEN,
    parameter int unsigned    ADDR_W    = 10,
    parameter logic [LEN-1:0] HALT_WORD = LEN'(HALT_WORD_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_start,
    program_loader_if.master    bus,
    output logic                out_busy,
    output logic                out_done,
    output logic                out_overflow,
    output logic [ADDR_W:0]     out_word_count,
    output logic                out_cpu_enable
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN-1:0]    r_wr_data;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic              r_cpu_enable;
    logic [CNT_W-1:0]  r_word_count;

    logic              w_accept;
    logic              w_word_valid;
    logic [LEN-1:0]    w_word;

    // Bytes arriving during WRITE start the next word, so none are lost at full rate.
    assign w_accept = bus.in_rx_done & ((r_state == LOAD) | (r_state == WRITE));

    word_assembler #(.LEN(LEN)) u_word_assembler (
        .clk            (clk),
        .reset          (reset),
        .i_byte         (bus.in_rx_data),
        .i_strobe       (w_accept),
        .i_clear        (in_start),
        .o_word_c       (w_word),
        .o_word_valid_c (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            // Start restarts from any state; a strobe already on the bus this cycle still completes.
            if (in_start) begin
                r_state      <= LOAD;
                r_addr       <= '0;
                r_word_count <= '0;
                r_overflow   <= 1'b0;
                r_done       <= 1'b0;
                r_cpu_enable <= 1'b0;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    LOAD: begin
                        if (w_word_valid) begin
                            r_wr_data <= w_word;
                            r_wr_en   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= WRITE;
                        end
                    end
                    WRITE: begin
                        r_word_count <= r_word_count + CNT_W'(1);
                        if (r_wr_data == HALT_WORD) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_cpu_enable <= 1'b1;
                        end else if (r_addr == LAST_ADDR) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_busy  <= 1'b1;
                            r_state <= LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_wr_en   = r_wr_en;
    assign bus.out_wr_addr = r_addr;
    assign bus.out_wr_data = r_wr_data;
    assign out_busy        = r_busy;
    assign out_done        = r_done;
    assign out_overflow    = r_overflow;
    assign out_word_count  = r_word_count;
    assign out_cpu_enable  = r_cpu_enable;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full-size instance plus a 4-word instance for overflow.
module tb_program_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        busy_a, done_a, ovf_a, cpu_a;
    logic [10:0] cnt_a;
    logic        busy_b, done_b, ovf_b, cpu_b;
    logic [2:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    logic [7:0]  prog  [12];
    logic [31:0] words [3];
    logic [31:0] words_b [4];

    program_loader_if #(.LEN(32), .ADDR_W(10)) bus_a ();
    program_loader_if #(.LEN(32), .ADDR_W(2))  bus_b ();

    program_loader #(.LEN(32), .ADDR_W(10)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_start       (start_a),
        .bus            (bus_a),
        .out_busy       (busy_a),
        .out_done       (done_a),
        .out_overflow   (ovf_a),
        .out_word_count (cnt_a),
        .out_cpu_enable (cpu_a)
    );

    program_loader #(.LEN(32), .ADDR_W(2)) u_dut_small (
        .clk            (clk),
        .reset          (reset),
        .in_start       (start_b),
        .bus            (bus_b),
        .out_busy       (busy_b),
        .out_done       (done_b),
        .out_overflow   (ovf_b),
        .out_word_count (cnt_b),
        .out_cpu_enable (cpu_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input logic [7:0] b);
        bus_a.in_rx_data = b;
        bus_a.in_rx_done = 1'b1;
        step();
        bus_a.in_rx_done = 1'b0;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_wr_en"},   32'(bus_a.out_wr_en),   0);
        chk({tag, "_wr_addr"}, 32'(bus_a.out_wr_addr), 0);
        chk({tag, "_wr_data"}, bus_a.out_wr_data,      0);
        chk({tag, "_busy"},    32'(busy_a),            0);
        chk({tag, "_done"},    32'(done_a),            0);
        chk({tag, "_ovf"},     32'(ovf_a),             0);
        chk({tag, "_count"},   32'(cnt_a),             0);
        chk({tag, "_cpu"},     32'(cpu_a),             0);
    endtask

    task automatic chk_wr_a(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_wr_en"},   32'(bus_a.out_wr_en),   1);
        chk({tag, "_wr_addr"}, 32'(bus_a.out_wr_addr), addr);
        chk({tag, "_wr_data"}, bus_a.out_wr_data,      data);
    endtask

    initial begin
        prog = '{8'h20, 8'h08, 8'h00, 8'h05,
                 8'h20, 8'h09, 8'h00, 8'h07,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        words   = '{32'h2008_0005, 32'h2009_0007, 32'hFFFF_FFFF};
        words_b = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
        bus_a.in_rx_data = 8'h00;
        bus_a.in_rx_done = 1'b0;
        bus_b.in_rx_data = 8'h00;
        bus_b.in_rx_done = 1'b0;

        // Reset held low for two cycles
        step();
        step();
        chk_zero_a("reset");
        chk("reset_b_done", 32'(done_b), 0);
        chk("reset_b_count", 32'(cnt_b), 0);
        reset = 1'b1;

        // Basic load with an idle cycle after every byte
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("start_busy", 32'(busy_a), 1);
        chk("start_done", 32'(done_a), 0);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                put_a(prog[w*4+k]);
                if (k == 3) chk_wr_a($sformatf("basic_w%0d", w), w, words[w]);
                else        chk($sformatf("basic_nowr_%0d_%0d", w, k), 32'(bus_a.out_wr_en), 0);
                step();
            end
            chk($sformatf("basic_count_%0d", w), 32'(cnt_a), w + 1);
        end
        chk("basic_done", 32'(done_a), 1);
        chk("basic_cpu",  32'(cpu_a),  1);
        chk("basic_ovf",  32'(ovf_a),  0);
        chk("basic_busy", 32'(busy_a), 0);

        // Bytes in DONE are ignored
        for (int k = 0; k < 4; k++) put_a(8'h55);
        step();
        chk("done_ignore_wr", 32'(bus_a.out_wr_en), 0);
        chk("done_ignore_count", 32'(cnt_a), 3);
        chk("done_ignore_done", 32'(done_a), 1);

        // Reload from DONE, then the same program back-to-back
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("reload_done",  32'(done_a), 0);
        chk("reload_busy",  32'(busy_a), 1);
        chk("reload_cpu",   32'(cpu_a),  0);
        chk("reload_count", 32'(cnt_a),  0);
        for (int i = 0; i < 12; i++) begin
            bus_a.in_rx_data = prog[i];
            bus_a.in_rx_done = 1'b1;
            step();
            if (i % 4 == 3) chk_wr_a($sformatf("b2b_w%0d", i / 4), i / 4, words[i/4]);
            else            chk($sformatf("b2b_nowr_%0d", i), 32'(bus_a.out_wr_en), 0);
        end
        bus_a.in_rx_done = 1'b0;
        step();
        chk("b2b_done",  32'(done_a), 1);
        chk("b2b_cpu",   32'(cpu_a),  1);
        chk("b2b_count", 32'(cnt_a),  3);

        // Restart mid-word; the byte coincident with start is dropped
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        put_a(8'hAA);
        put_a(8'hBB);
        start_a = 1'b1;
        bus_a.in_rx_data = 8'hCC;
        bus_a.in_rx_done = 1'b1;
        step();
        start_a = 1'b0;
        bus_a.in_rx_done = 1'b0;
        chk("restart_busy", 32'(busy_a), 1);
        put_a(8'h00);
        put_a(8'h00);
        put_a(8'h00);
        put_a(8'h01);
        chk_wr_a("restart_w0", 0, 32'h0000_0001);
        step();
        chk("restart_count1", 32'(cnt_a), 1);
        for (int k = 0; k < 4; k++) put_a(8'hFF);
        chk_wr_a("restart_w1", 1, 32'hFFFF_FFFF);
        step();
        chk("restart_done",  32'(done_a), 1);
        chk("restart_count", 32'(cnt_a),  2);

        // Reset asserted during the WRITE cycle
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        put_a(8'h12);
        put_a(8'h34);
        put_a(8'h56);
        put_a(8'h78);
        chk_wr_a("prerst", 0, 32'h1234_5678);
        reset = 1'b0;
        bus_a.in_rx_data = 8'h9A;
        bus_a.in_rx_done = 1'b1;
        step();
        reset = 1'b1;
        bus_a.in_rx_done = 1'b0;
        chk_zero_a("rst_mid");
        for (int k = 0; k < 4; k++) begin
            put_a(8'hFF);
            chk($sformatf("idle_ignore_wr_%0d", k), 32'(bus_a.out_wr_en), 0);
            chk($sformatf("idle_ignore_busy_%0d", k), 32'(busy_a), 0);
        end
        step();
        chk("idle_ignore_wr_end", 32'(bus_a.out_wr_en), 0);
        chk("idle_ignore_count",  32'(cnt_a), 0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) put_a(8'hFF);
        chk_wr_a("postrst_w0", 0, 32'hFFFF_FFFF);
        step();
        chk("postrst_done",  32'(done_a), 1);
        chk("postrst_count", 32'(cnt_a),  1);

        // Overflow: four non-HALT words fill the 4-entry memory
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_b.in_rx_data = 8'(i + 1);
            bus_b.in_rx_done = 1'b1;
            step();
            if (i % 4 == 3) begin
                chk($sformatf("ovf_w%0d_wr_en", i / 4),   32'(bus_b.out_wr_en),   1);
                chk($sformatf("ovf_w%0d_wr_addr", i / 4), 32'(bus_b.out_wr_addr), i / 4);
                chk($sformatf("ovf_w%0d_wr_data", i / 4), bus_b.out_wr_data,      words_b[i/4]);
            end
        end
        bus_b.in_rx_done = 1'b0;
        step();
        chk("ovf_done",    32'(done_b), 1);
        chk("ovf_flag",    32'(ovf_b),  1);
        chk("ovf_cpu",     32'(cpu_b),  0);
        chk("ovf_count",   32'(cnt_b),  4);
        chk("ovf_busy",    32'(busy_b), 0);
        chk("ovf_addr",    32'(bus_b.out_wr_addr), 3);
        chk("ovf_wr_idle", 32'(bus_b.out_wr_en),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
